vc_pop_arbiter: RTL and testbench
=================================

Name: vc_pop_arbiter

Overview:
- Round-robin scheduler that drains NUM_REQ virtual-channel source FIFOs (fifo_d0-style: registered pop data, pause and empty flags) into the two destination FIFOs d0/d1.
- Issues at most one pop per cycle.
- Routes the popped word by its MSB: 0 goes to d0, 1 goes to d1.
- Owns the almost-full/almost-empty threshold configuration driven to all FIFOs; sits between the VC FIFO bank and the d0/d1 FIFOs.

Parameters:
- DATA_SIZE, 6, word width of every FIFO.
- NUM_REQ, 4, number of source VC FIFOs (power of two, ≥2).
- AF_DEFAULT, 2'd3, afD_o value after reset.
- AE_DEFAULT, 2'd1, aeD_o value after reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset_L  in  1  asynchronous active-low reset.
- init  in  1  configuration request.
- umbral_af_in  in  2  almost-full threshold to program.
- umbral_ae_in  in  2  almost-empty threshold to program.
- empty_vc  in  NUM_REQ  empty flag per source FIFO.
- data_vc  in  NUM_REQ*DATA_SIZE  flattened source data outputs; slice k = [k*DATA_SIZE +: DATA_SIZE].
- pause_d0  in  1  d0 almost-full pause.
- pause_d1  in  1  d1 almost-full pause.
- pop_vc  out  NUM_REQ  one-hot pop to the source FIFOs.
- push_d0  out  1  push to d0.
- push_d1  out  1  push to d1.
- data_out  out  DATA_SIZE  word presented with push.
- afD_o  out  2  almost-full threshold to all FIFOs.
- aeD_o  out  2  almost-empty threshold to all FIFOs.
- idle_out  out  1  no traffic pending.
- state_o  out  2  current FSM state.

Behaviour:
- Reset (asynchronous, reset_L=0):
  - state=RESET, rr_ptr=0, valid_q=0, src_q=0.
  - pop_vc=0, push_d0=0, push_d1=0, data_out=0.
  - afD_o=AF_DEFAULT, aeD_o=AE_DEFAULT, idle_out=0.
- RESET: first clock edge with reset_L=1 goes to INIT.
- INIT:
  - While init=1, afD_o<=umbral_af_in and aeD_o<=umbral_ae_in on every edge.
  - init=0 goes to IDLE. No pops are issued in INIT.
- IDLE:
  - idle_out=1 when valid_q=0.
  - init=1 goes to INIT.
  - Otherwise, any empty_vc bit low goes to ACTIVE.
- ACTIVE, pop issue:
  - Pop is allowed when pause_d0=0, pause_d1=0 and at least one source is non-empty.
  - grant = first k with empty_vc[k]=0, searching cyclically from rr_ptr; pop_vc[grant]=1 (combinational).
  - On the edge: rr_ptr<=(grant+1) mod NUM_REQ, valid_q<=1, src_q<=grant.
  - When no pop is issued: valid_q<=0 and rr_ptr holds.
- ACTIVE, push stage (source data becomes valid the cycle after pop):
  - While valid_q=1: data_out=slice src_q of data_vc (combinational).
  - push_d0=~data_out[DATA_SIZE-1]; push_d1=data_out[DATA_SIZE-1].
  - Pop-to-push latency is exactly 1 cycle; throughput is 1 word/cycle.
- Exit from ACTIVE (evaluated after the pop decision):
  - init=1: no new pop; go to INIT. A pending push (valid_q=1) still completes in the INIT cycle.
  - All empty_vc=1 and no pop this cycle: go to IDLE. The pending push completes in the IDLE cycle.
- Invariants:
  - pop_vc is one-hot or zero.
  - A pop is never issued to an empty source.
  - push_d0 and push_d1 are never both high.
  - No push occurs without a pop one cycle earlier.
- Pause and reset mid-operation:
  - A pause stops new pops in the same cycle. An in-flight push still completes; the threshold margin absorbs it.
  - Pause toggling every cycle must neither lose nor duplicate words.
  - Reset mid-operation discards the pending push. The source FIFOs are reset by the same reset_L.
- state_o encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3.

Optional Feature:
- Macro: VC_ARB_STATS_EN.
- Defined: two extra outputs, cnt_d0 and cnt_d1, 8 bits each.
  - Each counts pushes to its destination and wraps at 255→0.
  - Cleared by reset and on entry to INIT.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package vc_arb_pkg:
  - State constants ST_RESET/ST_INIT/ST_IDLE/ST_ACTIVE.
  - Width constant for thresholds (2).
  - Destination-select bit position DATA_SIZE-1.
- Sub-module rr_grant: combinational cyclic priority picker. Inputs are the request vector and rr_ptr; outputs are a one-hot grant, the grant index, and any_req.

Test Plan:
- Reset then init=1 with umbral_af_in=2, umbral_ae_in=1 for 2 cycles, then init=0 -> afD_o=2, aeD_o=1, state_o=2, no pop.
- All 4 VCs hold 2 words, no pause -> pop order VC0,1,2,3,0,1,2,3 on consecutive cycles; push 1 cycle after each pop; idle_out=1 after the last push.
- VC1 holds 6'b100101 and 6'b000011 -> push_d1 with data_out=6'h25, then push_d0 with data_out=6'h03.
- pause_d0 raised the cycle after the first pop -> no pop that cycle, the pending push still asserted; pops resume the cycle after pause drops; no word lost.
- Only VC2 non-empty with rr_ptr=3 -> grant=2; rr_ptr becomes 3; pop_vc never hits an empty VC.
- reset_L pulsed low while valid_q=1 -> push_d0/push_d1 drop immediately; state_o=0; rr_ptr=0.

Source files
------------

// File: rtl/vc_arb_pkg.sv
// Shared constants for the VC pop arbiter: FSM state encoding, threshold width, route-bit helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vc_arb_pkg;

  // Width of the almost-full / almost-empty threshold fields driven to every FIFO
  localparam int THR_W = 2;

  // FSM encoding is visible on state_o, so the values are fixed
  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  // The destination is chosen by the top bit of the popped word
  function automatic int dst_bit(input int data_size);
    return data_size - 1;
  endfunction

endpackage

// File: rtl/vc_pop_arbiter_rr_grant.sv
// Cyclic priority picker: first requester at or after i_ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; callers gate the grant themselves.
module rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_any_req
);

  // Walk the offsets from the pointer; NUM_REQ is a power of two so the index wraps naturally
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    found     = 1'b0;
    idx       = '0;
    o_gnt     = '0;
    o_gnt_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = i_ptr + IDX_W'(off);
      if (!found && i_req[idx]) begin
        found     = 1'b1;
        o_gnt_idx = idx;
      end
    end
    o_gnt[o_gnt_idx] = found;
  end

  // Any requester at all
  always_comb begin
    o_any_req = |i_req;
  end

endmodule

// File: rtl/vc_pop_arbiter.sv
// Round-robin drain of NUM_REQ VC source FIFOs into d0/d1 (route by word MSB); owns FIFO thresholds.
// Latency: pop -> push exactly 1 cycle (source FIFO data is registered); 1 word/cycle throughput.
// Backpressure: pause_d0/pause_d1 block new pops the same cycle; an in-flight push still lands. Optional: VC_ARB_STATS_EN adds cnt_d0/cnt_d1.
module vc_pop_arbiter
  import vc_arb_pkg::*;
#(
  parameter int               DATA_SIZE  = 6,
  parameter int               NUM_REQ    = 4,
  parameter logic [THR_W-1:0] AF_DEFAULT = 2'd3,
  parameter logic [THR_W-1:0] AE_DEFAULT = 2'd1
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic                         init,
  input  logic [THR_W-1:0]             umbral_af_in,
  input  logic [THR_W-1:0]             umbral_ae_in,
  input  logic [NUM_REQ-1:0]           empty_vc,
  input  logic [NUM_REQ*DATA_SIZE-1:0] data_vc,
  input  logic                         pause_d0,
  input  logic                         pause_d1,
  output logic [NUM_REQ-1:0]           pop_vc,
  output logic                         push_d0,
  output logic                         push_d1,
  output logic [DATA_SIZE-1:0]         data_out,
  output logic [THR_W-1:0]             afD_o,
  output logic [THR_W-1:0]             aeD_o,
  output logic                         idle_out,
  output logic [1:0]                   state_o
`ifdef VC_ARB_STATS_EN
  ,
  output logic [7:0]                   cnt_d0,
  output logic [7:0]                   cnt_d1
`endif
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int DST_BIT = dst_bit(DATA_SIZE);

  state_t               r_state;
  state_t               w_next_state;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_src_q;
  logic                 r_valid_q;
  logic [THR_W-1:0]     r_af;
  logic [THR_W-1:0]     r_ae;
  logic [NUM_REQ-1:0]   w_req;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [IDX_W-1:0]     w_gnt_idx;
  logic                 w_any_req;
  logic                 w_pop;
  logic [DATA_SIZE-1:0] w_src_dat;

  assign w_req = ~empty_vc;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_grant (
    .i_req     (w_req),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any_req (w_any_req)
  );

  // Pop only in ACTIVE, with both destinations open, no config request, and something to take
  always_comb begin
    w_pop = (r_state == ST_ACTIVE) && !init && !pause_d0 && !pause_d1 && w_any_req;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state; leaving ACTIVE is decided after the pop decision for this cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RESET: w_next_state = ST_INIT;
      ST_INIT: begin
        if (!init) w_next_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (init)           w_next_state = ST_INIT;
        else if (w_any_req) w_next_state = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)                       w_next_state = ST_INIT;
        else if (!w_any_req && !w_pop)  w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_RESET;
    endcase
  end

  // Pop bookkeeping: remember which source was popped so its registered data can be pushed next cycle
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_rr_ptr  <= '0;
      r_src_q   <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= w_pop;
      if (w_pop) begin
        r_rr_ptr <= w_gnt_idx + IDX_W'(1);
        r_src_q  <= w_gnt_idx;
      end
    end
  end

  // Threshold configuration is sampled on every INIT-state edge while init is held
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_af <= AF_DEFAULT;
      r_ae <= AE_DEFAULT;
    end else if (r_state == ST_INIT && init) begin
      r_af <= umbral_af_in;
      r_ae <= umbral_ae_in;
    end
  end

  // Select the data slice of the source popped last cycle
  always_comb begin
    w_src_dat = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_src_q == IDX_W'(k)) w_src_dat = data_vc[k*DATA_SIZE +: DATA_SIZE];
    end
  end

  // FSM / datapath outputs; the push stage runs in any state so a pending word always lands
  always_comb begin
    pop_vc   = w_pop ? w_gnt : '0;
    data_out = r_valid_q ? w_src_dat : '0;
    push_d0  = r_valid_q && !data_out[DST_BIT];
    push_d1  = r_valid_q &&  data_out[DST_BIT];
    idle_out = (r_state == ST_IDLE) && !r_valid_q;
    afD_o    = r_af;
    aeD_o    = r_ae;
    state_o  = r_state;
  end

`ifdef VC_ARB_STATS_EN
  logic [7:0] r_cnt_d0;
  logic [7:0] r_cnt_d1;
  logic       w_init_entry;

  assign w_init_entry = (w_next_state == ST_INIT) && (r_state != ST_INIT);

  // Per-destination push counters, wrapping at 8 bits, cleared whenever INIT is entered
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_cnt_d0 <= '0;
      r_cnt_d1 <= '0;
    end else if (w_init_entry) begin
      r_cnt_d0 <= '0;
      r_cnt_d1 <= '0;
    end else begin
      if (push_d0) r_cnt_d0 <= r_cnt_d0 + 8'd1;
      if (push_d1) r_cnt_d1 <= r_cnt_d1 + 8'd1;
    end
  end

  assign cnt_d0 = r_cnt_d0;
  assign cnt_d1 = r_cnt_d1;
`endif

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench for vc_pop_arbiter with a behavioural model of the registered-output VC source FIFOs.
// Latency: source model presents a popped word on the edge after the pop.
// Backpressure: pauses driven directly by the scenarios.
module tb_vc_pop_arbiter;

  localparam int DS = 6;
  localparam int NR = 4;

  logic             clk = 1'b0;
  logic             reset_L = 1'b0;
  logic             init = 1'b0;
  logic [1:0]       umbral_af_in = 2'd0;
  logic [1:0]       umbral_ae_in = 2'd0;
  logic [NR-1:0]    empty_vc;
  logic [NR*DS-1:0] data_vc;
  logic             pause_d0 = 1'b0;
  logic             pause_d1 = 1'b0;
  logic [NR-1:0]    pop_vc;
  logic             push_d0;
  logic             push_d1;
  logic [DS-1:0]    data_out;
  logic [1:0]       afD_o;
  logic [1:0]       aeD_o;
  logic             idle_out;
  logic [1:0]       state_o;

  int total = 0;
  int bad   = 0;

  logic [DS-1:0] mem [NR][16];
  logic [3:0]    rd_ptr [NR];
  logic [3:0]    wr_ptr [NR];

  vc_pop_arbiter dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .init         (init),
    .umbral_af_in (umbral_af_in),
    .umbral_ae_in (umbral_ae_in),
    .empty_vc     (empty_vc),
    .data_vc      (data_vc),
    .pause_d0     (pause_d0),
    .pause_d1     (pause_d1),
    .pop_vc       (pop_vc),
    .push_d0      (push_d0),
    .push_d1      (push_d1),
    .data_out     (data_out),
    .afD_o        (afD_o),
    .aeD_o        (aeD_o),
    .idle_out     (idle_out),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  // Source FIFO model: registered read data, reset by the same reset_L
  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_vc <= '0;
      for (int k = 0; k < NR; k++) rd_ptr[k] <= 4'd0;
    end else begin
      for (int k = 0; k < NR; k++) begin
        if (pop_vc[k]) begin
          data_vc[k*DS +: DS] <= mem[k][rd_ptr[k]];
          rd_ptr[k]           <= rd_ptr[k] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    empty_vc = '0;
    for (int k = 0; k < NR; k++) empty_vc[k] = (rd_ptr[k] == wr_ptr[k]);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input int k, input logic [DS-1:0] w);
    mem[k][wr_ptr[k]] = w;
    wr_ptr[k] = wr_ptr[k] + 4'd1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    total++; if (pop_vc !== 4'b0) begin bad++; $display("FAIL reset_pop got=%b exp=0000", pop_vc); end
    total++; if ({push_d0, push_d1} !== 2'b00) begin bad++; $display("FAIL reset_push got=%b exp=00", {push_d0, push_d1}); end
    total++; if (data_out !== 6'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_out); end
    total++; if (afD_o !== 2'd3) begin bad++; $display("FAIL reset_af got=%0d exp=3", afD_o); end
    total++; if (aeD_o !== 2'd1) begin bad++; $display("FAIL reset_ae got=%0d exp=1", aeD_o); end
    total++; if (idle_out !== 1'b0) begin bad++; $display("FAIL reset_idle got=%b exp=0", idle_out); end
  endtask

  task automatic test_init();
    reset_L = 1'b1; init = 1'b1; umbral_af_in = 2'd2; umbral_ae_in = 2'd1;
    tick();
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL init_enter got=%0d exp=1", state_o); end
    total++; if (afD_o !== 2'd3) begin bad++; $display("FAIL init_af_early got=%0d exp=3", afD_o); end
    tick();
    total++; if (afD_o !== 2'd2) begin bad++; $display("FAIL init_af got=%0d exp=2", afD_o); end
    total++; if (aeD_o !== 2'd1) begin bad++; $display("FAIL init_ae got=%0d exp=1", aeD_o); end
    total++; if (pop_vc !== 4'b0) begin bad++; $display("FAIL init_pop got=%b exp=0000", pop_vc); end
    init = 1'b0;
    tick();
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL init_to_idle got=%0d exp=2", state_o); end
    total++; if (idle_out !== 1'b1) begin bad++; $display("FAIL init_idle_out got=%b exp=1", idle_out); end
    total++; if (pop_vc !== 4'b0) begin bad++; $display("FAIL idle_pop got=%b exp=0000", pop_vc); end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < NR; k++)
      for (int j = 0; j < 2; j++) load(k, 6'((j << 5) | (k + 1)));
    tick();
    total++; if (state_o !== 2'd3) begin bad++; $display("FAIL rr_active got=%0d exp=3", state_o); end
    for (int c = 0; c < 9; c++) begin
      logic [3:0] ep;
      logic [5:0] ed;
      logic       e0, e1;
      ep = (c < 8) ? 4'(1 << (c % 4)) : 4'd0;
      if (c >= 1) begin
        ed = 6'((((c - 1) / 4) << 5) | (((c - 1) % 4) + 1));
        e1 = (((c - 1) / 4) == 1);
        e0 = !e1;
      end else begin
        ed = 6'h00; e0 = 1'b0; e1 = 1'b0;
      end
      total++; if (pop_vc !== ep) begin bad++; $display("FAIL rr_pop c=%0d got=%b exp=%b", c, pop_vc, ep); end
      total++; if (push_d0 !== e0 || push_d1 !== e1) begin bad++; $display("FAIL rr_push c=%0d got=%b%b exp=%b%b", c, push_d0, push_d1, e0, e1); end
      total++; if (data_out !== ed) begin bad++; $display("FAIL rr_data c=%0d got=%h exp=%h", c, data_out, ed); end
      tick();
    end
    total++; if (state_o !== 2'd2 || idle_out !== 1'b1) begin bad++; $display("FAIL rr_idle got state=%0d idle=%b exp state=2 idle=1", state_o, idle_out); end
  endtask

  task automatic test_msb_route();
    load(1, 6'b100101); load(1, 6'b000011);
    tick();
    total++; if (pop_vc !== 4'b0010) begin bad++; $display("FAIL msb_pop0 got=%b exp=0010", pop_vc); end
    tick();
    total++; if (push_d1 !== 1'b1 || push_d0 !== 1'b0 || data_out !== 6'h25) begin bad++; $display("FAIL msb_d1 got=%b%b/%h exp=01/25", push_d0, push_d1, data_out); end
    total++; if (pop_vc !== 4'b0010) begin bad++; $display("FAIL msb_pop1 got=%b exp=0010", pop_vc); end
    tick();
    total++; if (push_d0 !== 1'b1 || push_d1 !== 1'b0 || data_out !== 6'h03) begin bad++; $display("FAIL msb_d0 got=%b%b/%h exp=10/03", push_d0, push_d1, data_out); end
    total++; if (pop_vc !== 4'b0000) begin bad++; $display("FAIL msb_pop2 got=%b exp=0000", pop_vc); end
    tick();
    total++; if (idle_out !== 1'b1) begin bad++; $display("FAIL msb_idle got=%b exp=1", idle_out); end
  endtask

  task automatic test_pause();
    for (int k = 0; k < NR; k++) load(k, 6'(16 + k));
    tick();
    total++; if (pop_vc !== 4'b0100) begin bad++; $display("FAIL pause_first got=%b exp=0100", pop_vc); end
    tick();
    pause_d0 = 1'b1; #1;
    total++; if (pop_vc !== 4'b0000) begin bad++; $display("FAIL pause_block got=%b exp=0000", pop_vc); end
    total++; if (push_d0 !== 1'b1 || data_out !== 6'h12) begin bad++; $display("FAIL pause_inflight got=%b/%h exp=1/12", push_d0, data_out); end
    tick();
    total++; if (pop_vc !== 4'b0000 || push_d0 !== 1'b0 || push_d1 !== 1'b0) begin bad++; $display("FAIL pause_hold got=%b %b%b exp=0000 00", pop_vc, push_d0, push_d1); end
    pause_d0 = 1'b0; #1;
    total++; if (pop_vc !== 4'b1000) begin bad++; $display("FAIL pause_resume got=%b exp=1000", pop_vc); end
    tick();
    total++; if (push_d0 !== 1'b1 || data_out !== 6'h13 || pop_vc !== 4'b0001) begin bad++; $display("FAIL pause_w3 got=%b/%h/%b exp=1/13/0001", push_d0, data_out, pop_vc); end
    tick();
    total++; if (push_d0 !== 1'b1 || data_out !== 6'h10 || pop_vc !== 4'b0010) begin bad++; $display("FAIL pause_w0 got=%b/%h/%b exp=1/10/0010", push_d0, data_out, pop_vc); end
    tick();
    total++; if (push_d0 !== 1'b1 || data_out !== 6'h11 || pop_vc !== 4'b0000) begin bad++; $display("FAIL pause_w1 got=%b/%h/%b exp=1/11/0000", push_d0, data_out, pop_vc); end
    tick();
    total++; if (idle_out !== 1'b1) begin bad++; $display("FAIL pause_idle got=%b exp=1", idle_out); end
  endtask

  task automatic test_pause_toggle();
    logic [5:0] got[$];
    for (int k = 0; k < NR; k++)
      for (int j = 0; j < 2; j++) load(k, 6'((j << 5) | (4 + k)));
    tick();
    for (int c = 0; c < 30; c++) begin
      if (push_d0 || push_d1) got.push_back(data_out);
      total++; if (push_d0 && push_d1) begin bad++; $display("FAIL tog_both_push c=%0d got=11 exp=not both", c); end
      total++; if ((pop_vc & empty_vc) !== 4'b0 || !$onehot0(pop_vc)) begin bad++; $display("FAIL tog_pop_legal c=%0d pop=%b empty=%b", c, pop_vc, empty_vc); end
      pause_d1 = ~pause_d1;
      tick();
    end
    pause_d1 = 1'b0;
    total++; if (got.size() != 8) begin bad++; $display("FAIL tog_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      logic [5:0] ew;
      ew = 6'(((i / 4) << 5) | (4 + ((2 + i) % 4)));
      total++; if (got[i] !== ew) begin bad++; $display("FAIL tog_word i=%0d got=%h exp=%h", i, got[i], ew); end
    end
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL tog_idle got=%0d exp=2", state_o); end
  endtask

  task automatic test_rr_wrap();
    load(2, 6'h07);
    tick();
    total++; if (pop_vc !== 4'b0100) begin bad++; $display("FAIL wrap_prep got=%b exp=0100", pop_vc); end
    tick(); tick();
    load(2, 6'h2A);
    tick();
    total++; if (pop_vc !== 4'b0100) begin bad++; $display("FAIL wrap_grant2 got=%b exp=0100", pop_vc); end
    tick();
    total++; if (push_d1 !== 1'b1 || data_out !== 6'h2A) begin bad++; $display("FAIL wrap_push got=%b/%h exp=1/2a", push_d1, data_out); end
    tick();
    load(2, 6'h0B); load(3, 6'h0C);
    tick();
    total++; if (pop_vc !== 4'b1000) begin bad++; $display("FAIL wrap_ptr3 got=%b exp=1000", pop_vc); end
    tick();
    total++; if (pop_vc !== 4'b0100 || data_out !== 6'h0C) begin bad++; $display("FAIL wrap_next got=%b/%h exp=0100/0c", pop_vc, data_out); end
    tick();
    total++; if (push_d0 !== 1'b1 || data_out !== 6'h0B) begin bad++; $display("FAIL wrap_last got=%b/%h exp=1/0b", push_d0, data_out); end
    tick();
  endtask

  task automatic test_init_exit();
    load(3, 6'h0D); load(3, 6'h0E);
    tick();
    total++; if (pop_vc !== 4'b1000) begin bad++; $display("FAIL iex_pop got=%b exp=1000", pop_vc); end
    tick();
    init = 1'b1; umbral_af_in = 2'd1; umbral_ae_in = 2'd2; #1;
    total++; if (pop_vc !== 4'b0000) begin bad++; $display("FAIL iex_nopop got=%b exp=0000", pop_vc); end
    total++; if (push_d0 !== 1'b1 || data_out !== 6'h0D) begin bad++; $display("FAIL iex_push got=%b/%h exp=1/0d", push_d0, data_out); end
    tick();
    total++; if (state_o !== 2'd1 || push_d0 !== 1'b0 || pop_vc !== 4'b0) begin bad++; $display("FAIL iex_init got=%0d/%b/%b exp=1/0/0000", state_o, push_d0, pop_vc); end
    tick();
    total++; if (afD_o !== 2'd1 || aeD_o !== 2'd2) begin bad++; $display("FAIL iex_thr got=%0d/%0d exp=1/2", afD_o, aeD_o); end
    init = 1'b0;
    tick();
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL iex_idle got=%0d exp=2", state_o); end
    tick();
    total++; if (pop_vc !== 4'b1000) begin bad++; $display("FAIL iex_resume got=%b exp=1000", pop_vc); end
    tick();
    total++; if (push_d0 !== 1'b1 || data_out !== 6'h0E) begin bad++; $display("FAIL iex_lastword got=%b/%h exp=1/0e", push_d0, data_out); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < NR; k++) load(k, 6'(36 + k));
    tick();
    total++; if (pop_vc !== 4'b0001) begin bad++; $display("FAIL rst_pre_pop got=%b exp=0001", pop_vc); end
    tick();
    total++; if (push_d1 !== 1'b1) begin bad++; $display("FAIL rst_pre_push got=%b exp=1", push_d1); end
    reset_L = 1'b0;
    for (int k = 0; k < NR; k++) wr_ptr[k] = 4'd0;
    #1;
    total++; if (push_d0 !== 1'b0 || push_d1 !== 1'b0) begin bad++; $display("FAIL rst_push_drop got=%b%b exp=00", push_d0, push_d1); end
    total++; if (state_o !== 2'd0 || pop_vc !== 4'b0 || data_out !== 6'h00) begin bad++; $display("FAIL rst_regs got=%0d/%b/%h exp=0/0000/00", state_o, pop_vc, data_out); end
    total++; if (afD_o !== 2'd3 || aeD_o !== 2'd1) begin bad++; $display("FAIL rst_thr got=%0d/%0d exp=3/1", afD_o, aeD_o); end
    tick();
    reset_L = 1'b1;
    tick(); tick();
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL rst_recover got=%0d exp=2", state_o); end
    for (int k = 0; k < NR; k++) load(k, 6'(k + 1));
    tick();
    total++; if (pop_vc !== 4'b0001) begin bad++; $display("FAIL rst_ptr0 got=%b exp=0001", pop_vc); end
    repeat (5) tick();
    total++; if (state_o !== 2'd2 || idle_out !== 1'b1) begin bad++; $display("FAIL rst_drain got=%0d/%b exp=2/1", state_o, idle_out); end
  endtask

  initial begin
    for (int k = 0; k < NR; k++) wr_ptr[k] = 4'd0;
    test_reset();
    test_init();
    test_round_robin();
    test_msb_route();
    test_pause();
    test_pause_toggle();
    test_rr_wrap();
    test_init_exit();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
